// File: rtl/sccb_req_arbiter.sv
// sccb_req_arbiter: two-requester round-robin front end for a shared SCCB/I2C
// engine. Requester A is boot config, B is runtime register access.
// Optional NACK retry is built when SCCB_ARB_RETRY_EN is defined; the default
// build aborts a transaction on its first NACK.
module sccb_req_arbiter #(
  parameter int MAX_RETRY     = 3,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iI2C_EN,
  input  logic        iA_REQ,
  input  logic        iB_REQ,
  input  logic        iA_WR,
  input  logic        iB_WR,
  input  logic [23:0] iA_DATA,
  input  logic [23:0] iB_DATA,
  output logic        oA_GNT,
  output logic        oB_GNT,
  output logic        oA_DONE,
  output logic        oB_DONE,
  output logic        oA_ERR,
  output logic        oB_ERR,
  output logic        oGO,
  output logic        oWR,
  output logic [23:0] oWDATA,
  input  logic        iEND,
  input  logic        iACK,
  input  logic [7:0]  iRDATA,
  output logic [7:0]  oRDATA,
  output logic        oBUSY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] START  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // Timeout counter counts 0..TIMEOUT_TICKS-1; the last value triggers abort.
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

`ifdef SCCB_ARB_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry;
`endif

  logic [1:0]    state;
  logic          ownerB;   // current owner: 0=A, 1=B
  logic          lastB;    // previous owner, reset to B so A wins the first tie
  logic          errFlag;  // current transaction has failed
  logic [TW-1:0] tmo;
  logic          pickB;

  // Round-robin pick: B wins if it is the only requester, or on a tie when A went last.
  assign pickB = iB_REQ && (!iA_REQ || !lastB);

  assign oBUSY = (state != IDLE);

  // Arbitration FSM; all state changes qualified by the engine tick, DONE/ERR self-clear.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      ownerB  <= 1'b0;
      lastB   <= 1'b1;
      errFlag <= 1'b0;
      tmo     <= '0;
      oA_GNT  <= 1'b0;
      oB_GNT  <= 1'b0;
      oA_DONE <= 1'b0;
      oB_DONE <= 1'b0;
      oA_ERR  <= 1'b0;
      oB_ERR  <= 1'b0;
      oGO     <= 1'b0;
      oWR     <= 1'b0;
      oWDATA  <= '0;
      oRDATA  <= '0;
`ifdef SCCB_ARB_RETRY_EN
      retry   <= '0;
`endif
    end else begin
      oA_DONE <= 1'b0;
      oB_DONE <= 1'b0;
      oA_ERR  <= 1'b0;
      oB_ERR  <= 1'b0;
      if (iI2C_EN) begin
        case (state)
          IDLE: begin
            if (iA_REQ || iB_REQ) begin
              ownerB  <= pickB;
              lastB   <= pickB;
              oA_GNT  <= !pickB;
              oB_GNT  <= pickB;
              oWR     <= pickB ? iB_WR : iA_WR;
              oWDATA  <= pickB ? iB_DATA : iA_DATA;
              oGO     <= 1'b1;
              tmo     <= '0;
              errFlag <= 1'b0;
`ifdef SCCB_ARB_RETRY_EN
              retry   <= '0;
`endif
              state   <= START;
            end
          end
          START: begin
            tmo <= tmo + 1'b1;
            // After a retry oGO is low for one tick; raise it before watching iEND.
            if (!oGO) oGO <= 1'b1;
            if (oGO && !iEND) begin
              state <= WAIT;
            end else if (tmo == TMO_LAST) begin
              state   <= FINISH;
              oGO     <= 1'b0;
              errFlag <= 1'b1;
            end
          end
          WAIT: begin
            tmo <= tmo + 1'b1;
            if (iEND) begin
              if (!iACK) begin
                if (!oWR) oRDATA <= iRDATA;
                state <= FINISH;
                oGO   <= 1'b0;
              end else begin
`ifdef SCCB_ARB_RETRY_EN
                if (retry < RETRY_MAX) begin
                  retry <= retry + 1'b1;
                  tmo   <= '0;
                  oGO   <= 1'b0;
                  state <= START;
                end else begin
                  state   <= FINISH;
                  oGO     <= 1'b0;
                  errFlag <= 1'b1;
                end
`else
                state   <= FINISH;
                oGO     <= 1'b0;
                errFlag <= 1'b1;
`endif
              end
            end else if (tmo == TMO_LAST) begin
              state   <= FINISH;
              oGO     <= 1'b0;
              errFlag <= 1'b1;
            end
          end
          default: begin // FINISH
            oA_DONE <= !ownerB;
            oB_DONE <= ownerB;
            oA_ERR  <= !ownerB && errFlag;
            oB_ERR  <= ownerB && errFlag;
            oA_GNT  <= 1'b0;
            oB_GNT  <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Directed bench for sccb_req_arbiter with a small behavioural engine model.
module tb_sccb_req_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iI2C_EN;
  logic        iA_REQ, iB_REQ, iA_WR, iB_WR;
  logic [23:0] iA_DATA, iB_DATA;
  logic        oA_GNT, oB_GNT, oA_DONE, oB_DONE, oA_ERR, oB_ERR;
  logic        oGO, oWR, oBUSY;
  logic [23:0] oWDATA;
  logic        iEND, iACK;
  logic [7:0]  iRDATA, oRDATA;

  int vecs = 0;
  int errs = 0;

  // engine model controls
  bit       engNack = 0, engHang = 0, engLong = 0, enDiv = 0;
  logic [7:0] engRd = 8'h00;

  sccb_req_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iI2C_EN(iI2C_EN),
    .iA_REQ(iA_REQ), .iB_REQ(iB_REQ), .iA_WR(iA_WR), .iB_WR(iB_WR),
    .iA_DATA(iA_DATA), .iB_DATA(iB_DATA),
    .oA_GNT(oA_GNT), .oB_GNT(oB_GNT), .oA_DONE(oA_DONE), .oB_DONE(oB_DONE),
    .oA_ERR(oA_ERR), .oB_ERR(oB_ERR), .oGO(oGO), .oWR(oWR), .oWDATA(oWDATA),
    .iEND(iEND), .iACK(iACK), .iRDATA(iRDATA), .oRDATA(oRDATA), .oBUSY(oBUSY)
  );

  always #20 iCLK = ~iCLK;

  // tick strobe: every cycle, or every other cycle when enDiv is set
  initial begin
    iI2C_EN = 1'b1;
    forever begin
      @(negedge iCLK);
      iI2C_EN = enDiv ? ~iI2C_EN : 1'b1;
    end
  end

  // engine: on each oGO rise go busy for a few cycles, then report end with ack/nack
  initial begin
    bit engPg;
    int engBusy;
    engPg = 0; engBusy = 0;
    iEND = 1'b1; iACK = 1'b0; iRDATA = 8'h00;
    forever begin
      @(negedge iCLK);
      iACK   = engNack;
      iRDATA = engRd;
      if (engBusy > 0) begin
        engBusy--;
        if (engBusy == 0) iEND = 1'b1;
      end else if (oGO && !engPg && !engHang) begin
        iEND = 1'b0;
        engBusy = engLong ? 20 : 3;
      end
      engPg = oGO;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // run until the given requester's DONE is seen at a negedge (bounded)
  task automatic runTo(input bit isB, input int budget, output bit ok,
                       output int rises, output int goCyc, output bit leak);
    bit pg;
    ok = 0; rises = 0; goCyc = 0; leak = 0; pg = oGO;
    for (int i = 0; i < budget; i++) begin
      @(negedge iCLK);
      if (oGO && !pg) rises++;
      pg = oGO;
      if (oGO) goCyc++;
      if (isB ? (oA_GNT | oA_DONE | oA_ERR) : (oB_GNT | oB_DONE | oB_ERR)) leak = 1;
      if (isB ? oB_DONE : oA_DONE) begin ok = 1; break; end
    end
  endtask

  task automatic waitGnt(input bit isB, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iCLK);
      if (isB ? oB_GNT : oA_GNT) begin ok = 1; break; end
    end
  endtask

  initial begin
    bit ok, leak, holdBad, both, doneSeen;
    int rises, goCyc, gcnt, aDone, bDone;
    logic [3:0] seq;
    bit pa, pb;

    iRST_N = 1'b0;
    iA_REQ = 0; iB_REQ = 0; iA_WR = 0; iB_WR = 0;
    iA_DATA = '0; iB_DATA = '0;
    repeat (3) @(negedge iCLK);

    // reset state
    chk("rst_ctl", {oA_GNT, oB_GNT, oA_DONE, oB_DONE, oA_ERR, oB_ERR, oGO, oWR, oBUSY}, 0);
    chk("rst_wdata", oWDATA, 0);
    chk("rst_rdata", oRDATA, 0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // A write 0x421280, ack, tick strobe every other cycle; A drops REQ mid-transfer
    enDiv = 1;
    iA_WR = 1; iA_DATA = 24'h421280; iA_REQ = 1;
    waitGnt(0, 20, ok);
    chk("a_gnt", ok, 1);
    chk("a_busy", oBUSY, 1);
    chk("a_go", oGO, 1);
    chk("a_wdata", oWDATA, 24'h421280);
    chk("a_wr", oWR, 1);
    iA_REQ = 0; iA_DATA = 24'hFFFFFF; iA_WR = 0;
    holdBad = 0; ok = 0; leak = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iCLK);
      if (oWDATA !== 24'h421280 || oWR !== 1'b1) holdBad = 1;
      if (oB_GNT | oB_DONE | oB_ERR) leak = 1;
      if (oA_DONE) begin ok = 1; break; end
    end
    chk("a_done", ok, 1);
    chk("a_err", oA_ERR, 0);
    chk("a_hold", holdBad, 0);
    chk("a_b_silent", leak, 0);
    chk("a_go_fin", oGO, 0);
    @(negedge iCLK);
    chk("a_done_pulse", oA_DONE, 0);
    chk("a_gnt_drop", oA_GNT, 0);
    repeat (4) @(negedge iCLK);
    chk("a_no_regrant", {oA_GNT, oBUSY}, 0);
    enDiv = 0;
    @(negedge iCLK);

    // B read 0x430A00, engine returns 0x76 with ack
    engRd = 8'h76;
    iB_WR = 0; iB_DATA = 24'h430A00; iB_REQ = 1;
    waitGnt(1, 20, ok);
    chk("b_gnt", ok, 1);
    chk("b_wr", oWR, 0);
    chk("b_wdata", oWDATA, 24'h430A00);
    runTo(1, 200, ok, rises, goCyc, leak);
    iB_REQ = 0;
    chk("b_done", ok, 1);
    chk("b_rdata", oRDATA, 8'h76);
    chk("b_err", oB_ERR, 0);
    chk("b_a_silent", leak, 0);
    repeat (3) @(negedge iCLK);

    // both requesting continuously from reset: A,B,A,B
    iRST_N = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    iA_WR = 1; iB_WR = 1; iA_DATA = 24'h111111; iB_DATA = 24'h222222;
    iA_REQ = 1; iB_REQ = 1;
    seq = '0; gcnt = 0; aDone = 0; bDone = 0; both = 0; pa = 0; pb = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge iCLK);
      if (oA_GNT && oB_GNT) both = 1;
      if (oA_GNT && !pa && gcnt < 4) begin seq[gcnt] = 1'b0; gcnt++; end
      if (oB_GNT && !pb && gcnt < 4) begin seq[gcnt] = 1'b1; gcnt++; end
      pa = oA_GNT; pb = oB_GNT;
      if (oA_DONE) aDone++;
      if (oB_DONE) bDone++;
      if (aDone + bDone == 4) begin iA_REQ = 0; iB_REQ = 0; break; end
    end
    chk("rr_count", gcnt, 4);
    chk("rr_seq", seq, 4'b1010);
    chk("rr_adone", aDone, 2);
    chk("rr_bdone", bDone, 2);
    chk("rr_excl", both, 0);
    repeat (3) @(negedge iCLK);
    chk("rr_idle", {oA_GNT, oB_GNT, oBUSY}, 0);

    // slave always NACKs
    engNack = 1;
    iA_WR = 1; iA_DATA = 24'h420000; iA_REQ = 1;
    runTo(0, 300, ok, rises, goCyc, leak);
    iA_REQ = 0;
    chk("nack_done", ok, 1);
    chk("nack_err", oA_ERR, 1);
`ifdef SCCB_ARB_RETRY_EN
    chk("nack_starts", rises, 4);
`else
    chk("nack_starts", rises, 1);
`endif
    chk("nack_b_silent", leak, 0);
    engNack = 0;
    repeat (3) @(negedge iCLK);

    // engine never leaves idle: timeout after 255 ticks
    engHang = 1;
    iA_REQ = 1;
    runTo(0, 400, ok, rises, goCyc, leak);
    iA_REQ = 0;
    chk("tmo_done", ok, 1);
    chk("tmo_err", oA_ERR, 1);
    chk("tmo_go_low", oGO, 0);
    chk("tmo_ticks", goCyc, 255);
    engHang = 0;
    repeat (3) @(negedge iCLK);

    // reset while the engine is mid-transfer (WAIT)
    engLong = 1;
    iA_REQ = 1;
    waitGnt(0, 20, ok);
    chk("rw_gnt", ok, 1);
    iA_REQ = 0;
    repeat (3) @(negedge iCLK);
    chk("rw_wait", {oGO, oBUSY, iEND}, 3'b110);
    iRST_N = 1'b0;
    #1;
    chk("rw_ctl", {oA_GNT, oB_GNT, oA_DONE, oB_DONE, oA_ERR, oB_ERR, oGO, oWR, oBUSY}, 0);
    chk("rw_wdata", oWDATA, 0);
    chk("rw_rdata", oRDATA, 0);
    doneSeen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      if (oA_DONE | oB_DONE) doneSeen = 1;
    end
    iRST_N = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge iCLK);
      if (oA_DONE | oB_DONE) doneSeen = 1;
    end
    chk("rw_no_done", doneSeen, 0);
    chk("rw_idle", oBUSY, 0);
    engLong = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sccb_req_arbiter.md
SCCB_REQ_ARBITER -- requirements
Module: sccb_req_arbiter

Interface
REQ-001 Parameter MAX_RETRY, default 3, NACK retries per transaction before error.
REQ-002 Parameter TIMEOUT_TICKS, default 255, max iI2C_EN ticks spent in START or WAIT before abort.
REQ-003 Ports: iCLK  input  1  system clock, 25 MHz.
REQ-004 iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 iI2C_EN  input  1  one-iCLK tick strobe, shared with the I2C engine; all FSM state changes occur only on cycles where it is high.
REQ-006 iA_REQ / iB_REQ  input  1 each  requester A (boot config) / B (runtime register access) request level.
REQ-007 iA_WR / iB_WR  input  1 each  1=write, 0=read.
REQ-008 iA_DATA / iB_DATA  input  24 each  {slave addr, sub addr, data}.
REQ-009 oA_GNT / oB_GNT  output  1 each  high while that requester owns the engine.
REQ-010 oA_DONE / oB_DONE  output  1 each  one-iCLK pulse, transaction finished.
REQ-011 oA_ERR / oB_ERR  output  1 each  one-iCLK pulse coincident with DONE on failure.
REQ-012 oGO  output  1  engine start; oWR  output  1  engine write/read; oWDATA  output  24  engine data.
REQ-013 iEND  input  1  engine idle (high) / transferring (low); iACK  input  1  0=slave acked.
REQ-014 iRDATA  input  8  engine read byte; oRDATA  output  8  read byte, captured at successful read completion.
REQ-015 oBUSY  output  1  high in any state except IDLE.

Function
REQ-016 FSM states IDLE, START, WAIT, FINISH; transitions only on iI2C_EN ticks.
REQ-017 IDLE: if any REQ high, select owner, latch owner's WR and DATA into oWR/oWDATA, assert GNT, go START.
REQ-018 Selection is round-robin: if both request, grant the one not granted last; first arbitration after reset favours A.
REQ-019 START: oGO=1; when iEND sampled low go WAIT.
REQ-020 WAIT: oGO stays 1; when iEND sampled high, sample iACK: 0 -> success, FINISH; 1 -> NACK handling per REQ-029/030.
REQ-021 FINISH: oGO=0, pulse owner DONE (and ERR if failed) for exactly one iCLK, deassert GNT, go IDLE; oRDATA updated only on successful read.
REQ-022 Timeout counter clears on START entry; reaching TIMEOUT_TICKS ticks in START or WAIT -> FINISH with ERR.
REQ-023 oWDATA/oWR held constant from grant until FINISH regardless of requester input changes.
REQ-024 Owner dropping REQ mid-transaction does not abort; DONE still pulses.
REQ-025 REQ of a requester still high in the cycle after its DONE is treated as a new request.
REQ-026 Non-owner never sees GNT, DONE or ERR.
REQ-027 oGO low for at least one tick between consecutive transactions (FINISH->IDLE->START).

Reset
REQ-028 iRST_N low: state IDLE, all outputs 0 (GNT, DONE, ERR, oGO, oWR, oWDATA, oRDATA, oBUSY), retry and timeout counters 0, last-owner = B; reset mid-transfer drops oGO immediately with no DONE.

Configuration
REQ-029 With SCCB_ARB_RETRY_EN defined: NACK with retry count < MAX_RETRY increments count, drops oGO one tick, re-enters START with same data; NACK at MAX_RETRY -> FINISH with ERR; count clears on grant.
REQ-030 Without SCCB_ARB_RETRY_EN: first NACK -> FINISH with ERR; no retry counter synthesized.

Verification
REQ-031 A only, write 0x421280, engine acks -> oA_GNT, oGO, oWDATA=0x421280, single oA_DONE pulse, oA_ERR=0, oB_* silent.
REQ-032 A and B requesting continuously from reset -> grants alternate A,B,A,B; each DONE pulses once per transaction.
REQ-033 B read 0x430A00, engine returns iRDATA=0x76 with ack -> oRDATA=0x76 at oB_DONE.
REQ-034 Retry enabled, MAX_RETRY=3, slave always NACKs -> 4 START entries, then oA_DONE+oA_ERR; disabled -> 1 attempt then ERR.
REQ-035 iEND held high after oGO for 255 ticks -> timeout, DONE+ERR, oGO low; reset asserted during WAIT -> all outputs 0 within same cycle, no DONE.
